sgd_trainer_v4: RTL

- Parametrised next-generation stochastic-gradient-descent linear-regression trainer.
- Fetches initial weights and then data points from an external RAM over a request/valid read port.
- Computes prediction and error per point using NUM_MUL time-multiplexed multiplier lanes, then updates bias and weights in signed fixed point with saturation.
- Exposes trained weights through an indexed read-back port. This replaces the shared tristate data bus.

---
 rtl/sgd_trainer_v4.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sgd_trainer_v4.sv
`default_nettype none
// ============================================================================
// Module      : sgd_trainer_v4
// Description : SGD linear-regression trainer. It fetches the initial weights
//               (address 0) and then data points (addresses 1..N) from an
//               external RAM. For each point it computes the prediction and
//               the error on NUM_MUL time-multiplexed lanes, then updates the
//               bias and the weights in saturating Q(LENGTH-FRAC).FRAC.
// Ports       : CLK, RST_N (async, active low)
//               start/feat/data_points/epoch/learn_rate - job setup (latched)
//               mem_req/mem_addr/mem_rdata/mem_rvalid  - RAM read port
//               w_idx/w_data                           - weight read-back
//               busy/done/sat_flag                     - status
// Revision    : 1.0 - initial release
// ============================================================================
module sgd_trainer_v4 #(
    parameter int ADDR_WIDTH   = 12,
    parameter int MAX_FEATURES = 15,
    parameter int LENGTH       = 16,
    parameter int FRAC         = 8,
    parameter int NUM_MUL      = 4,
    parameter int ACC_GUARD    = 4,
    parameter int DATA_WIDTH   = LENGTH*(MAX_FEATURES+1)
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              start,
    input  logic [$clog2(MAX_FEATURES+1)-1:0] feat,
    input  logic [ADDR_WIDTH-1:0]             data_points,
    input  logic [7:0]                        epoch,
    input  logic [3:0]                        learn_rate,
    output logic                              mem_req,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    input  logic                              mem_rvalid,
    input  logic [$clog2(MAX_FEATURES+1)-1:0] w_idx,
    output logic [LENGTH-1:0]                 w_data,
    output logic                              busy,
    output logic                              done,
    output logic                              sat_flag
);
    localparam int c_IW = $clog2(MAX_FEATURES+1);
    localparam int c_AW = LENGTH + ACC_GUARD;
    localparam int c_WW = 2*LENGTH + ACC_GUARD + 2;   // wide enough for every sum
    localparam int c_PW = c_IW + 1;                    // pass counter
    localparam int c_JW = c_IW + 2;                    // lane feature index

    localparam logic signed [c_WW-1:0]   c_MAXW = {{(c_WW-LENGTH+1){1'b0}}, {(LENGTH-1){1'b1}}};
    localparam logic signed [c_WW-1:0]   c_MINW = {{(c_WW-LENGTH+1){1'b1}}, {(LENGTH-1){1'b0}}};
    localparam logic signed [LENGTH-1:0] c_MAX  = {1'b0, {(LENGTH-1){1'b1}}};
    localparam logic signed [LENGTH-1:0] c_MIN  = {1'b1, {(LENGTH-1){1'b0}}};

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_LOADW_REQ  = 4'd1;
    localparam logic [3:0] S_LOADW_WAIT = 4'd2;
    localparam logic [3:0] S_FETCH_REQ  = 4'd3;
    localparam logic [3:0] S_FETCH_WAIT = 4'd4;
    localparam logic [3:0] S_PRED       = 4'd5;
    localparam logic [3:0] S_ERR        = 4'd6;
    localparam logic [3:0] S_UPD        = 4'd7;
    localparam logic [3:0] S_NEXT       = 4'd8;
    localparam logic [3:0] S_DONE       = 4'd9;

    function automatic logic signed [c_WW-1:0] f_sext(input logic signed [LENGTH-1:0] a);
        return {{(c_WW-LENGTH){a[LENGTH-1]}}, a};
    endfunction

    function automatic logic signed [c_WW-1:0] f_sext_acc(input logic signed [c_AW-1:0] a);
        return {{(c_WW-c_AW){a[c_AW-1]}}, a};
    endfunction

    // Full-width signed product, floored back to the fixed-point scale.
    function automatic logic signed [c_WW-1:0] f_prod(input logic signed [LENGTH-1:0] a,
                                                      input logic signed [LENGTH-1:0] b);
        logic signed [2*LENGTH-1:0] p;
        p = $signed({{LENGTH{a[LENGTH-1]}}, a}) * $signed({{LENGTH{b[LENGTH-1]}}, b});
        p = p >>> FRAC;
        return {{(c_WW-2*LENGTH){p[2*LENGTH-1]}}, p};
    endfunction

    function automatic logic f_clip(input logic signed [c_WW-1:0] v);
        return (v > c_MAXW) || (v < c_MINW);
    endfunction

    function automatic logic signed [LENGTH-1:0] f_sat(input logic signed [c_WW-1:0] v);
        if (v > c_MAXW)      return c_MAX;
        else if (v < c_MINW) return c_MIN;
        else                 return v[LENGTH-1:0];
    endfunction

    logic [3:0]               r_state, w_next_state;
    logic signed [LENGTH-1:0] r_w   [0:MAX_FEATURES];
    logic signed [LENGTH-1:0] r_buf [0:MAX_FEATURES];   // current point {y, x1..xF}
    logic signed [LENGTH-1:0] w_rd_slice [0:MAX_FEATURES];
    logic [c_IW-1:0]          r_feat;
    logic [ADDR_WIDTH-1:0]    r_n, r_dp;
    logic [7:0]               r_e, r_ep;
    logic [3:0]               r_lr;
    logic [c_PW-1:0]          r_pass, w_np;
    logic                     w_last_pass;
    logic signed [c_AW-1:0]   r_acc;
    logic signed [LENGTH-1:0] r_g, w_err;
    logic signed [c_WW-1:0]   w_err_diff, w_pred_sum, w_acc_sum, w_w0_sum;
    logic                     r_sat;

    logic signed [c_WW-1:0]   w_lane_pp  [NUM_MUL];
    logic signed [LENGTH-1:0] w_lane_new [NUM_MUL];
    logic                     w_lane_clip[NUM_MUL];
    logic                     w_lane_act [NUM_MUL];
    logic [c_IW-1:0]          w_lane_idx [NUM_MUL];

    // Slice 0 (y or W0) sits in the most significant LENGTH bits.
    for (genvar s = 0; s <= MAX_FEATURES; s++) begin : g_slice
        assign w_rd_slice[s] = mem_rdata[DATA_WIDTH-1-s*LENGTH -: LENGTH];
    end

    // Lane k serves feature j = pass*NUM_MUL + k + 1; beyond feat it is idle.
    for (genvar k = 0; k < NUM_MUL; k++) begin : g_lane
        logic [c_JW-1:0]          w_j;
        logic signed [LENGTH-1:0] w_wj, w_xj;
        logic signed [c_WW-1:0]   w_sum;
        assign w_j            = c_JW'(r_pass) * c_JW'(NUM_MUL) + c_JW'(k + 1);
        assign w_lane_act[k]  = (w_j <= c_JW'(r_feat));
        assign w_lane_idx[k]  = w_lane_act[k] ? w_j[c_IW-1:0] : '0;
        assign w_wj           = r_w[w_lane_idx[k]];
        assign w_xj           = w_lane_act[k] ? r_buf[w_lane_idx[k]] : '0;
        assign w_lane_pp[k]   = f_prod(w_wj, w_xj);
        assign w_sum          = f_sext(w_wj) + f_prod(r_g, w_xj);
        assign w_lane_new[k]  = f_sat(w_sum);
        assign w_lane_clip[k] = f_clip(w_sum);
    end

    always_comb begin
        w_np = (r_feat == '0) ? c_PW'(1) : c_PW'((int'(r_feat) + NUM_MUL - 1) / NUM_MUL);
        w_last_pass = (r_pass == w_np - c_PW'(1));
        w_pred_sum = '0;
        for (int k = 0; k < NUM_MUL; k++) begin
            w_pred_sum = w_pred_sum + w_lane_pp[k];
        end
        w_acc_sum  = ((r_pass == '0) ? f_sext(r_w[0]) : f_sext_acc(r_acc)) + w_pred_sum;
        w_err_diff = f_sext(r_buf[0]) - f_sext_acc(r_acc);
        w_err      = f_sat(w_err_diff);
        w_w0_sum   = f_sext(r_w[0]) + f_sext(r_g);
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next_state = S_LOADW_REQ;
            S_LOADW_REQ:    w_next_state = S_LOADW_WAIT;
            S_LOADW_WAIT:   if (mem_rvalid)
                                w_next_state = ((r_n == '0) || (r_e == '0)) ? S_DONE : S_FETCH_REQ;
            S_FETCH_REQ:    w_next_state = S_FETCH_WAIT;
            S_FETCH_WAIT:   if (mem_rvalid) w_next_state = S_PRED;
            S_PRED:         if (w_last_pass) w_next_state = S_ERR;
            S_ERR:          w_next_state = S_UPD;
            S_UPD:          if (w_last_pass) w_next_state = S_NEXT;
            S_NEXT:         if ((r_dp == r_n) && ({1'b0, r_ep} + 9'd1 == {1'b0, r_e}))
                                w_next_state = S_DONE;
                            else
                                w_next_state = S_FETCH_REQ;
            default:        w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_req  = (r_state == S_LOADW_REQ) || (r_state == S_FETCH_REQ);
        mem_addr = (r_state == S_FETCH_REQ) ? r_dp : '0;
        busy     = (r_state != S_IDLE) && (r_state != S_DONE);
        done     = (r_state == S_DONE);
    end

    // Datapath
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i <= MAX_FEATURES; i++) begin
                r_w[i]   <= '0;
                r_buf[i] <= '0;
            end
            r_feat <= '0;
            r_n    <= '0;
            r_dp   <= '0;
            r_e    <= '0;
            r_ep   <= '0;
            r_lr   <= '0;
            r_pass <= '0;
            r_acc  <= '0;
            r_g    <= '0;
            r_sat  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (start) begin
                    r_feat <= feat;
                    r_n    <= data_points;
                    r_e    <= epoch;
                    r_lr   <= learn_rate;
                    r_sat  <= 1'b0;
                    r_pass <= '0;
                end
                S_LOADW_WAIT: if (mem_rvalid) begin
                    for (int i = 0; i <= MAX_FEATURES; i++) r_w[i] <= w_rd_slice[i];
                    r_dp <= ADDR_WIDTH'(1);
                    r_ep <= '0;
                end
                S_FETCH_WAIT: if (mem_rvalid) begin
                    for (int i = 0; i <= MAX_FEATURES; i++) r_buf[i] <= w_rd_slice[i];
                    r_pass <= '0;
                end
                S_PRED: begin
                    r_acc  <= w_acc_sum[c_AW-1:0];
                    r_pass <= w_last_pass ? '0 : r_pass + c_PW'(1);
                end
                S_ERR: begin
                    r_g <= w_err >>> r_lr;
                    if (f_clip(w_err_diff)) r_sat <= 1'b1;
                end
                S_UPD: begin
                    if (r_pass == '0) begin
                        r_w[0] <= f_sat(w_w0_sum);
                        if (f_clip(w_w0_sum)) r_sat <= 1'b1;
                    end
                    for (int k = 0; k < NUM_MUL; k++) begin
                        if (w_lane_act[k]) begin
                            r_w[w_lane_idx[k]] <= w_lane_new[k];
                            if (w_lane_clip[k]) r_sat <= 1'b1;
                        end
                    end
                    r_pass <= w_last_pass ? '0 : r_pass + c_PW'(1);
                end
                S_NEXT: begin
                    if (r_dp == r_n) begin
                        r_dp <= ADDR_WIDTH'(1);
                        r_ep <= r_ep + 8'd1;
                    end else begin
                        r_dp <= r_dp + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_data   = r_w[w_idx];
    assign sat_flag = r_sat;

endmodule
`default_nettype wire
